// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
// Multi-cycle main controller for the P-series MIPS datapath. It decodes
// the instruction register and steps through IF/ID/EX/MEM/WB. It drives
// the IFU next-PC selects and PC write strobe, plus the datapath strobes
// and operand selects. It also counts retired instructions and keeps a
// sticky flag for unsupported encodings.
//
// Ports:
//   CLK, Reset   rising-edge clock, asynchronous active-high reset
//   instr        IR contents, stable from ID until the next IF
//   Zero         ALU zero flag (consumed by the IFU, not by this block)
//   PCWr/IRWr    PC and IR write enables
//   BEQ/JAL/JR   IFU next-PC selects, valid only in the PCWr cycle
//   RegWr/RegDst GRF write enable and destination select
//   ALUSrc/ALUOp ALU operand B select and operation
//   EXTOp        immediate extension mode
//   MemWr        DM write enable
//   MemtoReg     GRF write-data select
//   state        current state encoding
//   instr_done   pulse in the final state of each instruction
//   illegal      sticky unsupported-encoding flag
//   retired      count of completed instructions, wraps
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      instr,
  input  logic             Zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic             BEQ,
  output logic             JAL,
  output logic             JR,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             EXTOp,
  output logic             MemWr,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             lastState;

  logic [5:0] opCode;
  logic [5:0] funct;
  logic isAddu, isSubu, isJr, isOri, isLui, isLw, isSw, isBeq, isJal;
  logic isNop, isIllegal;

  // The branch outcome is resolved inside the IFU; the controller only
  // forwards the BEQ select, so Zero and the register/immediate fields
  // are intentionally not observed here.
  logic unusedInputs;
  assign unusedInputs = ^{Zero, instr[25:6]};

  // Instruction decode from opcode and funct fields
  assign opCode = instr[31:26];
  assign funct  = instr[5:0];

  assign isNop     = (instr == 32'd0);
  assign isAddu    = (opCode == 6'b000000) && (funct == 6'b100001);
  assign isSubu    = (opCode == 6'b000000) && (funct == 6'b100011);
  assign isJr      = (opCode == 6'b000000) && (funct == 6'b001000);
  assign isOri     = (opCode == 6'b001101);
  assign isLui     = (opCode == 6'b001111);
  assign isLw      = (opCode == 6'b100011);
  assign isSw      = (opCode == 6'b101011);
  assign isBeq     = (opCode == 6'b000100);
  assign isJal     = (opCode == 6'b000011);
  assign isIllegal = !(isNop || isAddu || isSubu || isJr || isOri || isLui ||
                       isLw || isSw || isBeq || isJal);

  // Next-state selection. lastState marks the final cycle of the current
  // instruction, which is where the PC is written and the instruction retires.
  always_comb begin
    state_d   = S_IF;
    lastState = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (isJal) begin
          state_d = S_WB;
        end else if (isNop || isIllegal) begin
          state_d   = S_IF;
          lastState = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (isLw || isSw) begin
          state_d = S_MEM;
        end else if (isBeq || isJr) begin
          state_d   = S_IF;
          lastState = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (isLw) begin
          state_d = S_WB;
        end else begin
          state_d   = S_IF;
          lastState = 1'b1;
        end
      end
      S_WB: begin
        state_d   = S_IF;
        lastState = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end

  // Output decode. Everything is forced low while Reset is held so that an
  // aborted instruction can never issue a write strobe.
  always_comb begin
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    BEQ        = 1'b0;
    JAL        = 1'b0;
    JR         = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 2'd0;
    ALUSrc     = 1'b0;
    ALUOp      = 2'd0;
    EXTOp      = 1'b0;
    MemWr      = 1'b0;
    MemtoReg   = 2'd0;
    instr_done = 1'b0;
    if (!Reset) begin
      if (state_q == S_IF) begin
        IRWr = 1'b1;
      end else begin
        if (isAddu) begin
          RegDst = 2'd1;
        end else if (isSubu) begin
          RegDst = 2'd1;
          ALUOp  = 2'd1;
        end else if (isOri) begin
          ALUSrc = 1'b1;
          ALUOp  = 2'd2;
        end else if (isLui) begin
          ALUSrc = 1'b1;
          ALUOp  = 2'd3;
        end else if (isLw || isSw) begin
          ALUSrc   = 1'b1;
          EXTOp    = 1'b1;
          MemtoReg = isLw ? 2'd1 : 2'd0;
        end else if (isBeq) begin
          ALUOp = 2'd1;
        end else if (isJal) begin
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
        PCWr       = lastState;
        instr_done = lastState;
        BEQ        = lastState && isBeq;
        JAL        = lastState && isJal;
        JR         = lastState && isJr;
        RegWr      = (state_q == S_WB);
        MemWr      = (state_q == S_MEM) && isSw;
      end
    end
  end

  // State register, retired counter and sticky illegal flag. The illegal
  // flag latches on the edge leaving ID, once the IR contents are valid.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lastState) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if ((state_q == S_ID) && isIllegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule
